// File: rtl/rr_packet_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_packet_arbiter
//  Purpose  : Weighted round-robin packet arbiter for NUM_PORTS requesters
//             sharing one sink. A winner keeps the grant for a whole packet,
//             may win several packets in a row according to its weight, and
//             is force-released by a beat-count watchdog if last never comes.
//  Revision : 1.0  initial release
// ============================================================================
module rr_packet_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int WEIGHT_W  = 3,
    parameter int MAX_BEATS = 16,
    parameter int ID_W      = $clog2(NUM_PORTS)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_PORTS-1:0]          req_i,
    input  logic [NUM_PORTS-1:0]          last_i,
    input  logic [NUM_PORTS*WEIGHT_W-1:0] weight_i,
    input  logic                          ack_i,
    output logic [NUM_PORTS-1:0]          gnt_o,
    output logic [ID_W-1:0]               gnt_id_o,
    output logic                          gnt_vld_o,
    output logic                          timeout_o
);

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_GRANT = 1'b1;

    // Beat counter is wide enough to hold MAX_BEATS itself.
    localparam int                  c_BEAT_W    = (MAX_BEATS > 1) ? $clog2(MAX_BEATS + 1) : 1;
    localparam logic [c_BEAT_W-1:0] c_MAX_BEATS = c_BEAT_W'(MAX_BEATS);
    localparam bit                  c_WDOG_EN   = (MAX_BEATS != 0);

    logic [0:0]           r_state;
    logic [NUM_PORTS-1:0] r_gnt;
    logic [ID_W-1:0]      r_gnt_id;
    logic [NUM_PORTS-1:0] r_mask;
    logic [WEIGHT_W-1:0]  r_credit;
    logic [c_BEAT_W-1:0]  r_beat_cnt;
    logic                 r_timeout;

    logic [0:0]           w_state_nxt;
    logic [NUM_PORTS-1:0] w_gnt_nxt;
    logic [ID_W-1:0]      w_gnt_id_nxt;
    logic [NUM_PORTS-1:0] w_mask_nxt;
    logic [WEIGHT_W-1:0]  w_credit_nxt;
    logic [c_BEAT_W-1:0]  w_beat_nxt;
    logic                 w_timeout_nxt;

    logic [NUM_PORTS-1:0] w_masked_req;
    logic [ID_W-1:0]      w_pick_m_id;
    logic [ID_W-1:0]      w_pick_u_id;
    logic [ID_W-1:0]      w_win_id;
    logic [NUM_PORTS-1:0] w_win_oh;
    logic [NUM_PORTS-1:0] w_prev_oh;
    logic [WEIGHT_W-1:0]  w_win_weight;
    logic [WEIGHT_W-1:0]  w_load_credit;
    logic [WEIGHT_W-1:0]  w_credit_dec;
    logic [NUM_PORTS-1:0] w_above;
    logic                 w_gnt_vld;
    logic                 w_req_g;
    logic                 w_last_g;
    logic                 w_xfer;
    logic [c_BEAT_W-1:0]  w_beat_inc;
    logic                 w_wdog_hit;

    assign w_masked_req = req_i & r_mask;
    assign w_win_id     = (|w_masked_req) ? w_pick_m_id : w_pick_u_id;
    assign w_gnt_vld    = |r_gnt;
    assign w_req_g      = req_i[r_gnt_id];
    assign w_last_g     = last_i[r_gnt_id];
    assign w_xfer       = w_gnt_vld & ack_i & w_req_g;
    assign w_beat_inc   = r_beat_cnt + c_BEAT_W'(1);
    assign w_wdog_hit   = c_WDOG_EN && (w_beat_inc == c_MAX_BEATS);
    // A zero weight still entitles the port to one packet per turn.
    assign w_load_credit = (w_win_weight == '0) ? WEIGHT_W'(1) : w_win_weight;
    // Credit saturates at zero rather than wrapping.
    assign w_credit_dec  = (r_credit != '0) ? (r_credit - WEIGHT_W'(1)) : '0;

    // Lowest-index picks (masked and unmasked), one-hot forms, winner weight
    // and the "ports strictly above the current grant" rotation mask.
    always_comb begin
        w_pick_m_id  = '0;
        w_pick_u_id  = '0;
        w_win_weight = '0;
        w_win_oh     = '0;
        w_prev_oh    = '0;
        w_above      = '0;
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            if (w_masked_req[p]) w_pick_m_id = ID_W'(p);
            if (req_i[p])        w_pick_u_id = ID_W'(p);
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (ID_W'(p) == w_win_id) begin
                w_win_weight = weight_i[p*WEIGHT_W +: WEIGHT_W];
                w_win_oh[p]  = 1'b1;
            end
            w_prev_oh[p] = (ID_W'(p) == r_gnt_id);
            w_above[p]   = (ID_W'(p) > r_gnt_id);
        end
    end

    // Next-state logic: arbitration in IDLE, packet tracking in GRANT.
    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_gnt_id_nxt  = r_gnt_id;
        w_mask_nxt    = r_mask;
        w_credit_nxt  = r_credit;
        w_beat_nxt    = r_beat_cnt;
        w_timeout_nxt = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_beat_nxt = '0;
                if (w_req_g && (r_credit != '0)) begin
                    // Previous winner still has credit: keep its turn.
                    w_state_nxt = c_ST_GRANT;
                    w_gnt_nxt   = w_prev_oh;
                end else if (|req_i) begin
                    w_state_nxt  = c_ST_GRANT;
                    w_gnt_nxt    = w_win_oh;
                    w_gnt_id_nxt = w_win_id;
                    w_credit_nxt = w_load_credit;
                end
            end
            c_ST_GRANT: begin
                if (!w_req_g) begin
                    // Abort: requester dropped without a last transfer.
                    w_state_nxt  = c_ST_IDLE;
                    w_gnt_nxt    = '0;
                    w_credit_nxt = '0;
                    w_beat_nxt   = '0;
                    w_mask_nxt   = w_above;
                end else if (w_xfer) begin
                    if (w_last_g) begin
                        w_state_nxt  = c_ST_IDLE;
                        w_gnt_nxt    = '0;
                        w_credit_nxt = w_credit_dec;
                        w_beat_nxt   = '0;
                        w_mask_nxt   = w_above;
                    end else if (w_wdog_hit) begin
                        w_state_nxt   = c_ST_IDLE;
                        w_gnt_nxt     = '0;
                        w_credit_nxt  = '0;
                        w_beat_nxt    = '0;
                        w_mask_nxt    = w_above;
                        w_timeout_nxt = 1'b1;
                    end else begin
                        w_beat_nxt = w_beat_inc;
                    end
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    // State and output registers; reset asserts asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= c_ST_IDLE;
            r_gnt      <= '0;
            r_gnt_id   <= '0;
            r_mask     <= '1;
            r_credit   <= '0;
            r_beat_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_gnt_id   <= w_gnt_id_nxt;
            r_mask     <= w_mask_nxt;
            r_credit   <= w_credit_nxt;
            r_beat_cnt <= w_beat_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end

    assign gnt_o     = r_gnt;
    assign gnt_id_o  = r_gnt_id;
    assign gnt_vld_o = w_gnt_vld;
    assign timeout_o = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rr_packet_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rr_packet_arbiter
//  Purpose  : Directed bench for rr_packet_arbiter (MAX_BEATS 16 and 4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_rr_packet_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  req = '0;
    logic [3:0]  last = '0;
    logic [11:0] wgt = '0;
    logic        ack = 1'b0;

    logic [3:0]  gnt,  gnt4;
    logic [1:0]  gnt_id, gnt_id4;
    logic        gnt_vld, gnt_vld4;
    logic        timeout, timeout4;

    int n_vec = 0;
    int n_err = 0;

    rr_packet_arbiter #(.NUM_PORTS(4), .WEIGHT_W(3), .MAX_BEATS(16)) dut (
        .clk(clk), .reset_n(reset_n), .req_i(req), .last_i(last),
        .weight_i(wgt), .ack_i(ack), .gnt_o(gnt), .gnt_id_o(gnt_id),
        .gnt_vld_o(gnt_vld), .timeout_o(timeout)
    );

    rr_packet_arbiter #(.NUM_PORTS(4), .WEIGHT_W(3), .MAX_BEATS(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .req_i(req), .last_i(last),
        .weight_i(wgt), .ack_i(ack), .gnt_o(gnt4), .gnt_id_o(gnt_id4),
        .gnt_vld_o(gnt_vld4), .timeout_o(timeout4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        req = '0; last = '0; ack = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck, want finish");
        $fatal(1);
    end

    initial begin
        int         seq1 [5];
        int         seq2 [8];
        logic [3:0] oh;
        seq1 = '{0, 1, 2, 3, 0};
        seq2 = '{0, 1, 1, 1, 0, 1, 1, 1};

        // ---- reset state and test 1: equal weights, all requesting ----
        apply_reset();
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_id", gnt_id, 2'd0);
        chk("rst_vld", gnt_vld, 1'b0);
        chk("rst_to", timeout, 1'b0);
        wgt = {3'd1, 3'd1, 3'd1, 3'd1};
        req = 4'b1111; last = 4'b1111; ack = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            oh = 4'b0001 << seq1[k];
            chk("t1_id", gnt_id, seq1[k]);
            chk("t1_gnt", gnt, oh);
            tick();
            chk("t1_bubble", gnt_vld, 1'b0);
            chk("t1_idhold", gnt_id, seq1[k]);
            if (k == 4) req = 4'b0000;
        end
        tick();
        chk("t1_quiet", gnt_vld, 1'b0);

        // ---- test 2: weight[1]=3, ports 0 and 1 requesting ----
        apply_reset();
        wgt = {3'd1, 3'd1, 3'd3, 3'd1};
        req = 4'b0011; last = 4'b0011; ack = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            oh = 4'b0001 << seq2[k];
            chk("t2_id", gnt_id, seq2[k]);
            chk("t2_gnt", gnt, oh);
            tick();
            chk("t2_bubble", gnt_vld, 1'b0);
            if (k == 7) req = 4'b0000;
        end

        // ---- test 3: 4-beat packet on port 2, ack toggling ----
        apply_reset();
        wgt = {3'd1, 3'd1, 3'd1, 3'd1};
        req = 4'b0100; last = 4'b0000; ack = 1'b1;   // ack while idle is ignored
        tick();
        for (int c = 1; c <= 8; c++) begin
            chk("t3_hold", gnt, 4'b0100);
            req  = 4'b0101;                           // port 0 intrudes mid-packet
            ack  = (c % 2 == 0);
            last = (c == 8) ? 4'b0100 : 4'b0000;
            tick();
        end
        chk("t3_release", gnt_vld, 1'b0);
        chk("t3_to", timeout, 1'b0);
        req = 4'b0001; last = 4'b0001; ack = 1'b1;
        tick();
        chk("t3_next", gnt, 4'b0001);
        req = 4'b0000;
        tick();

        // ---- test 4: watchdog at MAX_BEATS=4 on port 3 ----
        apply_reset();
        req = 4'b1000; last = 4'b0000; ack = 1'b1;
        tick();
        chk("t4_gnt", gnt4, 4'b1000);
        for (int b = 1; b <= 3; b++) begin
            tick();
            chk("t4_hold", gnt4, 4'b1000);
            chk("t4_noto", timeout4, 1'b0);
        end
        tick();
        chk("t4_release", gnt4, 4'b0000);
        chk("t4_pulse", timeout4, 1'b1);
        chk("t4_big_noto", timeout, 1'b0);
        req = 4'b1001;
        tick();
        chk("t4_next", gnt4, 4'b0001);
        chk("t4_pulse_end", timeout4, 1'b0);
        req = 4'b0000;
        tick();

        // ---- test 5: port 1 aborts mid-packet ----
        apply_reset();
        req = 4'b0010; ack = 1'b0; last = 4'b0000;
        tick();
        chk("t5_gnt", gnt, 4'b0010);
        ack = 1'b1;
        tick();
        chk("t5_hold", gnt, 4'b0010);
        req = 4'b0100; ack = 1'b0;
        tick();
        chk("t5_abort", gnt, 4'b0000);
        chk("t5_to", timeout, 1'b0);
        tick();
        chk("t5_next", gnt_id, 2'd2);
        chk("t5_next_gnt", gnt, 4'b0100);
        req = 4'b0000;

        // ---- test 6: async reset during a grant ----
        apply_reset();
        req = 4'b0010; last = 4'b0010; ack = 1'b1;
        tick();
        chk("t6_p1", gnt, 4'b0010);
        tick();
        chk("t6_p1_done", gnt_vld, 1'b0);
        req = 4'b0100; last = 4'b0000; ack = 1'b0;
        tick();
        chk("t6_p2", gnt, 4'b0100);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_async_gnt", gnt, 4'b0000);
        chk("t6_async_vld", gnt_vld, 1'b0);
        chk("t6_async_id", gnt_id, 2'd0);
        #1 reset_n = 1'b1;
        req = 4'b1010;
        tick();
        chk("t6_after_rst", gnt, 4'b0010);
        chk("t6_after_id", gnt_id, 2'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
